// File: rtl/flow_pkg.sv
// Shared types and arithmetic helpers for the streaming flow blocks.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package flow_pkg;

    // Block/frame sideband that travels unchanged alongside each beat.
    typedef struct packed {
        logic sob;
        logic eob;
        logic sof;
    } flow_side_t;

    // Clamp result: flag plus the clamped value (only the low bits are consumed).
    typedef struct packed {
        logic        sat;
        logic [63:0] val;
    } flow_sat_t;

    // Add one half LSB of the discarded bits, then arithmetic shift.
    // This rounds exact halves toward +infinity.
    function automatic logic signed [63:0] flow_round_shift(
        input logic signed [63:0] p,
        input int                 shift
    );
        logic signed [63:0] r;
        if (shift > 0) begin
            r = (p + (64'sd1 <<< (shift - 1))) >>> shift;
        end else begin
            r = p;
        end
        return r;
    endfunction

    // Clamp a signed value into the out_w-bit two's-complement range.
    function automatic flow_sat_t flow_sat(
        input logic signed [63:0] r,
        input int                 out_w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        flow_sat_t          s;
        hi    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (out_w - 1));
        s.sat = 1'b0;
        s.val = r;
        if (r > hi) begin
            s.sat = 1'b1;
            s.val = hi;
        end else if (r < lo) begin
            s.sat = 1'b1;
            s.val = lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/flow_skid.sv
// Generic 2-entry valid/ready skid buffer with a registered ready.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: a beat arriving while main is stalled lands in spare; ready drops the next cycle.
module flow_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_vld;
    logic         spare_vld;
    logic         spare_next;
    logic         rdy;
    logic [W-1:0] main_dat;
    logic [W-1:0] spare_dat;
    logic         push;
    logic         pop;

    assign push      = in_valid && rdy;
    assign pop       = main_vld && out_ready;
    assign in_ready  = rdy;
    assign out_valid = main_vld;
    assign out_data  = main_dat;

    // Spare occupancy after this edge; ready is its registered inverse.
    always_comb begin
        spare_next = spare_vld;
        if (!main_vld || pop) begin
            spare_next = spare_vld && push;
        end else if (push) begin
            spare_next = 1'b1;
        end
    end

    // Main/spare entries: refill main from spare first to keep beat order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld  <= 1'b0;
            spare_vld <= 1'b0;
            main_dat  <= '0;
            spare_dat <= '0;
            rdy       <= 1'b1;
        end else begin
            if (!main_vld || pop) begin
                if (spare_vld) begin
                    main_vld <= 1'b1;
                    main_dat <= spare_dat;
                    if (push) begin
                        spare_dat <= in_data;
                    end
                end else begin
                    main_vld <= push;
                    if (push) begin
                        main_dat <= in_data;
                    end
                end
            end else if (push) begin
                spare_dat <= in_data;
            end
            spare_vld <= spare_next;
            rdy       <= !spare_next;
        end
    end

endmodule

// File: rtl/flow_quant_mult.sv
// N-lane signed x unsigned multiply, round-half-up shift and narrow (clamp when FLOW_QUANT_SAT_EN, else wrap).
// Latency: PIPE cycles (PIPE-1 lock-step arithmetic stages plus a 2-entry skid output).
// Backpressure: full valid/ready; in_ready is the skid's registered ready, stages hold while it is low.
module flow_quant_mult
    import flow_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = 16,
    parameter int MULT_W = 10,
    parameter int SHIFT  = 8,
    parameter int OUT_W  = 12,
    parameter int PIPE   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N-1:0][DATA_W-1:0]    in_data,
    input  logic [N-1:0][MULT_W-1:0]    in_mult,
    input  logic                        in_sob,
    input  logic                        in_eob,
    input  logic                        in_sof,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N-1:0][OUT_W-1:0]     out_data,
    output logic [N-1:0]                out_sat,
    output logic                        out_sob,
    output logic                        out_eob,
    output logic                        out_sof
);

    localparam int PW = $bits(flow_side_t) + N + N * OUT_W;

    logic [N-1:0][OUT_W-1:0] lane_dat;
    logic [N-1:0]            lane_sat;
    logic [PW-1:0]           new_pay;
    logic [PIPE-2:0]         stg_vld;
    logic [PIPE-2:0][PW-1:0] stg_pay;
    logic                    skid_rdy;
    logic [PW-1:0]           skid_dat;
`ifdef FLOW_QUANT_SAT_EN
    flow_sat_t               lane_clamp;
`endif

    // Full-precision signed product, then rounded shift.
    function automatic logic signed [63:0] lane_round(
        input logic [DATA_W-1:0] d,
        input logic [MULT_W-1:0] m
    );
        logic signed [DATA_W+MULT_W:0] p;
        logic signed [63:0]            p64;
        p   = $signed(d) * $signed({1'b0, m});
        p64 = p;
        return flow_round_shift(p64, SHIFT);
    endfunction

    // Per-lane arithmetic feeding the first stage.
    always_comb begin
        lane_dat = '0;
        lane_sat = '0;
`ifdef FLOW_QUANT_SAT_EN
        lane_clamp = '0;
`endif
        for (int i = 0; i < N; i++) begin
`ifdef FLOW_QUANT_SAT_EN
            lane_clamp  = flow_sat(lane_round(in_data[i], in_mult[i]), OUT_W);
            lane_dat[i] = lane_clamp.val[OUT_W-1:0];
            lane_sat[i] = lane_clamp.sat;
`else
            lane_dat[i] = OUT_W'(lane_round(in_data[i], in_mult[i]));
`endif
        end
    end

    assign new_pay  = {in_sob, in_eob, in_sof, lane_sat, lane_dat};
    assign in_ready = skid_rdy;

    // Lock-step stage chain: everything moves only when the skid can take a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld <= '0;
            stg_pay <= '0;
        end else if (skid_rdy) begin
            stg_vld[0] <= in_valid;
            stg_pay[0] <= new_pay;
            for (int s = 1; s < PIPE - 1; s++) begin
                stg_vld[s] <= stg_vld[s-1];
                stg_pay[s] <= stg_pay[s-1];
            end
        end
    end

    flow_skid #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (stg_vld[PIPE-2]),
        .in_ready  (skid_rdy),
        .in_data   (stg_pay[PIPE-2]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_dat)
    );

    assign {out_sob, out_eob, out_sof, out_sat, out_data} = skid_dat;

endmodule

// File: tb/tb_flow_quant_mult.sv
module tb_flow_quant_mult;

    localparam int N      = 2;
    localparam int DATA_W = 16;
    localparam int MULT_W = 10;
    localparam int SHIFT  = 8;
    localparam int OUT_W  = 12;
    localparam int PIPE   = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic [N-1:0][DATA_W-1:0]  in_data;
    logic [N-1:0][MULT_W-1:0]  in_mult;
    logic                      in_sob, in_eob, in_sof;
    logic                      out_valid;
    logic                      out_ready;
    logic [N-1:0][OUT_W-1:0]   out_data;
    logic [N-1:0]              out_sat;
    logic                      out_sob, out_eob, out_sof;

    always #5 clk = ~clk;

    flow_quant_mult #(
        .N(N), .DATA_W(DATA_W), .MULT_W(MULT_W), .SHIFT(SHIFT), .OUT_W(OUT_W), .PIPE(PIPE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mult(in_mult),
        .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .out_sob(out_sob), .out_eob(out_eob), .out_sof(out_sof)
    );

    typedef struct {
        logic [N-1:0][OUT_W-1:0] d;
        logic [N-1:0]            s;
        logic [2:0]              side;
        int                      c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    int   cyc    = 0;
    bit   chk_lat   = 1'b0;
    bit   rnd_mode  = 1'b0;
    bit   burst_chk = 1'b0;
    int   burst_left = 0;
    int   stall_run  = 0;
    bit   stalled    = 1'b0;
    logic [N-1:0][OUT_W-1:0] h_d;
    logic [N-1:0]            h_s;
    logic [2:0]              h_side;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: round-half-up shift of the full product, then clamp or wrap.
    function automatic logic [OUT_W:0] model(input int d, input int m);
        longint p, r, hi, lo;
        logic   sat;
        p = longint'(d) * longint'(m);
        r = (SHIFT > 0) ? ((p + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT) : p;
        hi  = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo  = -(longint'(1) <<< (OUT_W - 1));
        sat = 1'b0;
`ifdef FLOW_QUANT_SAT_EN
        if (r > hi) begin r = hi; sat = 1'b1; end
        else if (r < lo) begin r = lo; sat = 1'b1; end
`endif
        return {sat, r[OUT_W-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (burst_left > 0) begin
            out_ready = 1'b0;
            burst_left--;
        end else if (rnd_mode) begin
            out_ready = 1'($urandom_range(0, 1));
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic send(input logic [N-1:0][DATA_W-1:0] d, input logic [N-1:0][MULT_W-1:0] m,
                        input logic [2:0] side, input logic [N-1:0][OUT_W-1:0] ed,
                        input logic [N-1:0] es);
        bit   done = 1'b0;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_mult  = m;
        {in_sob, in_eob, in_sof} = side;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.d = ed; e.s = es; e.side = side; e.c = cyc;
                q.push_back(e);
                done = 1'b1;
            end
            tick();
        end
        chk("send_accepted", 64'(done), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [2:0] side);
        logic [N-1:0][DATA_W-1:0] d;
        logic [N-1:0][MULT_W-1:0] m;
        logic [N-1:0][OUT_W-1:0]  ed;
        logic [N-1:0]             es;
        logic signed [DATA_W-1:0] ds;
        logic [OUT_W:0]           mo;
        for (int l = 0; l < N; l++) begin
            d[l]  = DATA_W'($urandom_range(0, 65535));
            m[l]  = MULT_W'($urandom_range(0, 1023));
            ds    = d[l];
            mo    = model(int'(ds), int'(m[l]));
            ed[l] = mo[OUT_W-1:0];
            es[l] = mo[OUT_W];
        end
        send(d, m, side, ed, es);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && q.size() > 0; k++) tick();
        chk("drain_empty", 64'(q.size()), 64'd0);
        repeat (10) tick();
    endtask

    // Output monitor: scoreboard pop, hold-while-stalled and ready-fall checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled   = 1'b0;
            stall_run = 0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(h_d));
                chk("hold_sat", 64'(out_sat), 64'(h_s));
                chk("hold_side", 64'({out_sob, out_eob, out_sof}), 64'(h_side));
            end
            if (out_valid && out_ready) begin
                chk("beat_expected", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.d));
                    chk("out_sat", 64'(out_sat), 64'(e.s));
                    chk("out_side", 64'({out_sob, out_eob, out_sof}), 64'(e.side));
                    if (chk_lat) chk("latency", 64'(cyc), 64'(e.c + PIPE));
                end
            end
            stalled = out_valid && !out_ready;
            h_d     = out_data;
            h_s     = out_sat;
            h_side  = {out_sob, out_eob, out_sof};
            if (!out_ready) stall_run++;
            else stall_run = 0;
            if (burst_chk && stall_run == 3) chk("ready_fall", 64'(in_ready), 64'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [N-1:0][DATA_W-1:0] d;
        logic [N-1:0][MULT_W-1:0] m;
        logic [N-1:0][OUT_W-1:0]  ed;
        logic [N-1:0]             es;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_mult = '0; {in_sob, in_eob, in_sof} = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        chk("rst_out_side", 64'({out_sob, out_eob, out_sof}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Directed arithmetic, back-to-back with out_ready high: exact latency.
        chk_lat = 1'b1;
        d[0] = 16'd100;  m[0] = 10'd256;  ed[0] = 12'd100;   es[0] = 1'b0;
        d[1] = 16'(-3);  m[1] = 10'd128;  ed[1] = 12'(-1);   es[1] = 1'b0;
        send(d, m, 3'b101, ed, es);
        d[0] = 16'd3;      m[0] = 10'd128;  ed[0] = 12'd2;   es[0] = 1'b0;
        d[1] = 16'd32767;  m[1] = 10'd1023;
`ifdef FLOW_QUANT_SAT_EN
        ed[1] = 12'd2047; es[1] = 1'b1;
`else
        ed[1] = 12'(-132); es[1] = 1'b0;
`endif
        send(d, m, 3'b000, ed, es);
        d[0] = 16'h8000; m[0] = 10'd1023;
`ifdef FLOW_QUANT_SAT_EN
        ed[0] = 12'h800; es[0] = 1'b1;
`else
        ed[0] = 12'd128; es[0] = 1'b0;
`endif
        d[1] = 16'd0; m[1] = 10'd0; ed[1] = 12'd0; es[1] = 1'b0;
        send(d, m, 3'b010, ed, es);
        d[0] = 16'd1;    m[0] = 10'd128; ed[0] = 12'd1; es[0] = 1'b0;
        d[1] = 16'(-1);  m[1] = 10'd128; ed[1] = 12'd0; es[1] = 1'b0;
        send(d, m, 3'b001, ed, es);
        drain();
        chk_lat = 1'b0;

        // 32-beat block under random out_ready with a 5-cycle stall burst.
        rnd_mode = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 8) begin
                burst_left = 5;
                burst_chk  = 1'b1;
            end
            if (i == 20) burst_chk = 1'b0;
            send_rand({i == 0, i == 31, i == 0});
        end
        rnd_mode = 1'b0;
        drain();

        // Reset in the middle of a block: in-flight beats must vanish.
        for (int i = 0; i < 10; i++) send_rand({i == 0, 1'b0, i == 0});
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        tick();
        for (int i = 0; i < 6; i++) send_rand({i == 0, i == 5, 1'b0});
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
